cs_byte_packer: RTL and testbench

- Upstream feeder for the checksum stage: collects a serial byte stream and packs it into WIDTH_DATA-bit blocks.
- Each complete block is presented as a one-cycle data/out_valid pulse. The checksum stage samples data on out_valid.
- A frame ends on in_last. A partial final block is zero-padded, which leaves the one's-complement sum unchanged.
- Also reports per-block byte count and end-of-frame for downstream bookkeeping.

---
 rtl/cs_byte_packer_if.sv | 35 +++
 rtl/cs_byte_packer.sv | 93 +++++++++
 tb/tb_cs_byte_packer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cs_byte_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cs_byte_packer_if
//  Description : Byte-stream input and packed-block output bundle for the
//                checksum-stage byte packer.
//                master : upstream/consumer side (drives in_*, reads block)
//                slave  : packer side (reads in_*, drives block outputs)
//  Ports       : in_valid, in_byte[7:0], in_last      -> packer
//                data[WIDTH_DATA-1:0], out_valid,
//                out_last, out_nbytes[5:0]             <- packer
//  Revision    : 1.0  initial release
// ============================================================================
interface cs_byte_packer_if #(
    parameter int WIDTH_DATA = 128
);
    logic                  in_valid;
    logic [7:0]            in_byte;
    logic                  in_last;
    logic [WIDTH_DATA-1:0] data;
    logic                  out_valid;
    logic                  out_last;
    logic [5:0]            out_nbytes;

    modport master (
        output in_valid, in_byte, in_last,
        input  data, out_valid, out_last, out_nbytes
    );

    modport slave (
        input  in_valid, in_byte, in_last,
        output data, out_valid, out_last, out_nbytes
    );
endinterface

`default_nettype wire

// File: rtl/cs_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : cs_byte_packer
//  Description : Packs a serial byte stream into WIDTH_DATA-bit blocks for the
//                checksum stage. The first byte of a block lands in the MSB
//                byte. A block is emitted when it fills or when a byte with
//                in_last arrives; a short final block is zero-padded.
//  Ports       : clk         rising-edge clock
//                rst_n       asynchronous active-low reset
//                bus.in_*    byte stream in (no backpressure)
//                bus.data    packed block, held until the next emit
//                bus.out_valid / out_last / out_nbytes  one-cycle emit pulse
//  Revision    : 1.0  initial release
// ============================================================================
module cs_byte_packer #(
    parameter int WIDTH_DATA = 128
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    cs_byte_packer_if.slave  bus
);

    localparam int         BYTES       = WIDTH_DATA / 8;
    localparam logic [5:0] c_last_slot = 6'(BYTES - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_fill = 1'b1;

    logic [0:0]            r_state;
    logic [5:0]            r_cnt;
    logic [WIDTH_DATA-1:0] r_shift;
    logic [WIDTH_DATA-1:0] r_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [5:0]            r_out_nbytes;

    logic [5:0]            w_slot;
    logic [WIDTH_DATA-1:0] w_ins;
    logic [WIDTH_DATA-1:0] w_blk;
    logic                  w_emit;

    // In IDLE the block is empty, so the incoming byte always goes to slot 0.
    assign w_slot = (r_state == c_st_idle) ? 6'd0 : r_cnt;

    // Place the incoming byte at its slot; slot 0 is the top byte.
    assign w_ins  = {bus.in_byte, {(WIDTH_DATA-8){1'b0}}} >> {w_slot, 3'b000};

    // The shift register is cleared on every emit, so slots past the current
    // one are already zero and OR-ing in the new byte yields the padded block.
    assign w_blk  = r_shift | w_ins;

    assign w_emit = bus.in_valid && (bus.in_last || (w_slot == c_last_slot));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_cnt        <= 6'd0;
            r_shift      <= '0;
            r_data       <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_nbytes <= 6'd0;
        end else begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_nbytes <= 6'd0;

            if (bus.in_valid) begin
                if (w_emit) begin
                    r_data       <= w_blk;
                    r_out_valid  <= 1'b1;
                    r_out_last   <= bus.in_last;
                    r_out_nbytes <= w_slot + 6'd1;
                    r_shift      <= '0;
                    r_cnt        <= 6'd0;
                    r_state      <= c_st_idle;
                end else begin
                    r_shift      <= w_blk;
                    r_cnt        <= w_slot + 6'd1;
                    r_state      <= c_st_fill;
                end
            end
        end
    end

    assign bus.data       = r_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_last   = r_out_last;
    assign bus.out_nbytes = r_out_nbytes;

endmodule

`default_nettype wire

// File: tb/tb_cs_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cs_byte_packer
//  Description : Scoreboard bench for cs_byte_packer at WIDTH_DATA=128 and 64.
//                Stimulus pushes the expected block (with its arrival cycle)
//                into a queue; a monitor pops and compares on every pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cs_byte_packer;

    typedef struct packed {
        logic [255:0] data;
        logic         last;
        logic [5:0]   nb;
        logic [31:0]  cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] cyc;
    int          n_cmp;
    int          n_err;

    exp_t q128[$];
    exp_t q64[$];
    exp_t e128;
    exp_t e64;

    cs_byte_packer_if #(.WIDTH_DATA(128)) bus128 ();
    cs_byte_packer_if #(.WIDTH_DATA(64))  bus64  ();

    cs_byte_packer #(.WIDTH_DATA(128)) u_dut128 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus128.slave)
    );

    cs_byte_packer #(.WIDTH_DATA(64)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (bus128.out_valid) begin
            n_cmp++;
            if (q128.size() == 0) begin
                n_err++;
                $display("FAIL w128_unexpected_pulse: got data=%h nb=%0d last=%0b at cyc %0d, required no pulse",
                         bus128.data, bus128.out_nbytes, bus128.out_last, cyc);
            end else begin
                e128 = q128.pop_front();
                if (bus128.data !== e128.data[127:0] || bus128.out_last !== e128.last ||
                    bus128.out_nbytes !== e128.nb || cyc !== e128.cyc) begin
                    n_err++;
                    $display("FAIL w128_block: got data=%h last=%0b nb=%0d cyc=%0d, required data=%h last=%0b nb=%0d cyc=%0d",
                             bus128.data, bus128.out_last, bus128.out_nbytes, cyc,
                             e128.data[127:0], e128.last, e128.nb, e128.cyc);
                end
            end
        end else if (rst_n && (bus128.out_last !== 1'b0 || bus128.out_nbytes !== 6'd0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL w128_idle_outputs: got last=%0b nb=%0d, required 0/0", bus128.out_last, bus128.out_nbytes);
        end

        if (bus64.out_valid) begin
            n_cmp++;
            if (q64.size() == 0) begin
                n_err++;
                $display("FAIL w64_unexpected_pulse: got data=%h nb=%0d last=%0b at cyc %0d, required no pulse",
                         bus64.data, bus64.out_nbytes, bus64.out_last, cyc);
            end else begin
                e64 = q64.pop_front();
                if (bus64.data !== e64.data[63:0] || bus64.out_last !== e64.last ||
                    bus64.out_nbytes !== e64.nb || cyc !== e64.cyc) begin
                    n_err++;
                    $display("FAIL w64_block: got data=%h last=%0b nb=%0d cyc=%0d, required data=%h last=%0b nb=%0d cyc=%0d",
                             bus64.data, bus64.out_last, bus64.out_nbytes, cyc,
                             e64.data[63:0], e64.last, e64.nb, e64.cyc);
                end
            end
        end else if (rst_n && (bus64.out_last !== 1'b0 || bus64.out_nbytes !== 6'd0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL w64_idle_outputs: got last=%0b nb=%0d, required 0/0", bus64.out_last, bus64.out_nbytes);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive128(input logic v, input logic [7:0] b, input logic l);
        bus128.in_valid = v;
        bus128.in_byte  = b;
        bus128.in_last  = l;
        step();
        bus128.in_valid = 1'b0;
        bus128.in_last  = 1'b0;
    endtask

    task automatic drive64(input logic v, input logic [7:0] b, input logic l);
        bus64.in_valid = v;
        bus64.in_byte  = b;
        bus64.in_last  = l;
        step();
        bus64.in_valid = 1'b0;
        bus64.in_last  = 1'b0;
    endtask

    // Called right after the emitting byte's edge: the pulse is visible in
    // the cycle that edge opens.
    task automatic push128(input logic [127:0] d, input logic l, input logic [5:0] nb);
        exp_t e;
        e.data = {128'd0, d};
        e.last = l;
        e.nb   = nb;
        e.cyc  = cyc;
        q128.push_back(e);
    endtask

    task automatic push64(input logic [63:0] d, input logic l, input logic [5:0] nb);
        exp_t e;
        e.data = {192'd0, d};
        e.last = l;
        e.nb   = nb;
        e.cyc  = cyc;
        q64.push_back(e);
    endtask

    task automatic check_state(input string name, input logic [127:0] got, input logic [127:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus128.in_valid = 1'b0; bus128.in_byte = 8'h00; bus128.in_last = 1'b0;
        bus64.in_valid  = 1'b0; bus64.in_byte  = 8'h00; bus64.in_last  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        check_state("rst_w128_data",   bus128.data, 128'd0);
        check_state("rst_w128_ctrl",   {121'd0, bus128.out_valid, bus128.out_last, bus128.out_nbytes}, 128'd0);
        check_state("rst_w64_data",    {64'd0, bus64.data}, 128'd0);
        check_state("rst_w64_ctrl",    {121'd0, bus64.out_valid, bus64.out_last, bus64.out_nbytes}, 128'd0);

        // 16 bytes 0x01..0x10, in_last on the 16th
        for (int i = 1; i <= 16; i++) drive128(1'b1, 8'(i), i == 16);
        push128(128'h0102030405060708090A0B0C0D0E0F10, 1'b1, 6'd16);
        step();

        // 3-byte frame
        drive128(1'b1, 8'hAA, 1'b0);
        drive128(1'b1, 8'hBB, 1'b0);
        drive128(1'b1, 8'hCC, 1'b1);
        push128(128'hAABBCC00_00000000_00000000_00000000, 1'b1, 6'd3);
        step();

        // 20 continuous bytes 0x00..0x13
        for (int i = 0; i < 20; i++) begin
            drive128(1'b1, 8'(i), i == 19);
            if (i == 15) push128(128'h000102030405060708090A0B0C0D0E0F, 1'b0, 6'd16);
        end
        push128(128'h10111213_00000000_00000000_00000000, 1'b1, 6'd4);
        step();

        // 5 bytes with a 7-cycle gap after byte 2; stray in_last during gap
        drive128(1'b1, 8'h31, 1'b0);
        drive128(1'b1, 8'h32, 1'b0);
        for (int i = 0; i < 7; i++) drive128(1'b0, 8'hEE, i == 3);
        drive128(1'b1, 8'h33, 1'b0);
        drive128(1'b1, 8'h34, 1'b0);
        drive128(1'b1, 8'h35, 1'b1);
        push128(128'h31323334_35000000_00000000_00000000, 1'b1, 6'd5);
        step();
        step();
        check_state("hold_w128_data", bus128.data, 128'h31323334_35000000_00000000_00000000);

        // 9 bytes, then reset discards them
        for (int i = 0; i < 9; i++) drive128(1'b1, 8'h50 + 8'(i), 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_state("midrst_w128_data", bus128.data, 128'd0);
        drive128(1'b1, 8'h7E, 1'b1);
        push128(128'h7E000000_00000000_00000000_00000000, 1'b1, 6'd1);
        step();

        // W=64: 8 x 0xFF, in_last on the 8th
        for (int i = 1; i <= 8; i++) drive64(1'b1, 8'hFF, i == 8);
        push64(64'hFFFFFFFFFFFFFFFF, 1'b1, 6'd8);

        // Bounded drain of the scoreboards
        for (int i = 0; i < 20 && (q128.size() != 0 || q64.size() != 0); i++) step();
        repeat (4) step();
        n_cmp++;
        if (q128.size() != 0 || q64.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d pending blocks, required 0/0", q128.size(), q64.size());
        end

        check_state("final_w128_data", bus128.data, 128'h7E000000_00000000_00000000_00000000);
        check_state("final_w64_data",  {64'd0, bus64.data}, {64'd0, 64'hFFFFFFFFFFFFFFFF});

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
